tdm_mux8_tx: RTL

//   8-lane time-division multiplexer transmitter; the sending end of the 1-to-8 demux link.

---
 rtl/tdm_pkg.sv | 39 +++
 rtl/tdm_lane_buf.sv | 64 ++++++
 rtl/tdm_mux8_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
//   Shared definitions for the 8-lane TDM transmitter.
//   - N_LANES / SEL_W : lane count and slot-select width
//   - state_e         : transmitter FSM states (ST_IDLE, ST_SCAN)
//   - next_full()     : first set bit of a lane mask, searching upward from a
//                       start index with wrap-around (used by the skip-empty
//                       build only)
// -----------------------------------------------------------------------------
package tdm_pkg;

  localparam int N_LANES = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Returns the first index at or above 'start' (wrapping) whose bit is set
  // in 'full'. Returns 'start' when the mask is empty.
  function automatic logic [SEL_W-1:0] next_full(input logic [N_LANES-1:0] full,
                                                 input logic [SEL_W-1:0]   start);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] res;
    logic             found;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      idx = start + SEL_W'(k);
      if (!found && full[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tdm_lane_buf.sv
// -----------------------------------------------------------------------------
// tdm_lane_buf
//   One-entry holding register for a single TDM lane.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     in_data    : lane word offered by the producer
//     in_valid   : producer offers a word
//     in_ready   : register can accept (empty, or being drained this cycle)
//     take       : this lane's slot fires this cycle (word leaves)
//     full       : register holds a word
//     q          : held word
// -----------------------------------------------------------------------------
module tdm_lane_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              take,
  output logic              full,
  output logic [DATA_W-1:0] q
);

  logic              full_d, full_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              capture;

  // A word leaving in the same cycle frees the slot for a new one.
  assign in_ready = ~full_q | take;
  assign capture  = in_valid & in_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    full_d = full_q;
    data_d = data_q;
    if (capture) begin
      full_d = 1'b1;
      data_d = in_data;
    end else if (take) begin
      full_d = 1'b0;
    end
  end

  // NOTE: the data register is reset along with the flag so a discarded word
  // can never reappear; it is a single word, not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state so every flop
      // samples its pre-edge value regardless of statement order.
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign q    = data_q;

endmodule

// File: rtl/tdm_mux8_tx.sv
// -----------------------------------------------------------------------------
// tdm_mux8_tx
//   8-lane time-division multiplexer transmitter. Each lane feeds a one-entry
//   holding register; the FSM scans slots round-robin, presenting one word
//   per beat on a shared bus together with its 3-bit slot select.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     en         : 1 = run frames; 0 = stop at next frame boundary
//     in_data    : lane i word at in_data[i*DATA_W +: DATA_W]
//     in_valid   : per-lane word offer
//     in_ready   : per-lane holding register can accept
//     out_data   : word of current slot (0 when unused)
//     out_sel    : current slot index (demux control)
//     out_used   : out_data carries a real lane word
//     out_frame  : first beat of a frame
//     out_valid  : beat present
//     out_ready  : downstream accepts the beat
//   Build option: define TDM_SKIP_EMPTY_EN to present only full lanes
//   (empty slots are skipped, frames are delimited by slot wrap-around).
//   Outputs depend only on registered state, never combinationally on in_*.
// -----------------------------------------------------------------------------
module tdm_mux8_tx
  import tdm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [N_LANES*DATA_W-1:0] in_data,
  input  logic [N_LANES-1:0]        in_valid,
  output logic [N_LANES-1:0]        in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_used,
  output logic                      out_frame,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_LANES - 1);

  state_e             state_d, state_q;
  logic [SEL_W-1:0]   slot_d, slot_q;
  logic [N_LANES-1:0] hold_full;
  logic [N_LANES-1:0] take;
  logic [DATA_W-1:0]  hold_word [N_LANES];

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    tdm_lane_buf #(.DATA_W(DATA_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data[gi*DATA_W +: DATA_W]),
      .in_valid (in_valid[gi]),
      .in_ready (in_ready[gi]),
      .take     (take[gi]),
      .full     (hold_full[gi]),
      .q        (hold_word[gi])
    );
  end

  // Only the lane whose slot fires is drained.
  always_comb begin
    take = '0;
    if (out_valid && out_ready) take[out_sel] = 1'b1;
  end

`ifdef TDM_SKIP_EMPTY_EN
  // prev_q is the last fired slot; it is parked at LAST_SLOT after reset or
  // IDLE so the first beat always reads as a wrap (frame start).
  logic [SEL_W-1:0]   prev_d, prev_q;
  logic [N_LANES-1:0] full_nxt;

  // Occupancy after this edge, so a lane captured now can be current next
  // cycle. This feeds only registers, never the outputs.
  assign full_nxt = (hold_full & ~take) | (in_valid & in_ready);

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    prev_d    = prev_q;
    out_sel   = slot_q;
    out_valid = 1'b0;
    out_used  = 1'b0;
    out_frame = 1'b0;
    out_data  = '0;
    case (state_q)
      ST_IDLE: begin
        prev_d = LAST_SLOT;
        slot_d = next_full(full_nxt, '0);
        if (en) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        out_valid = hold_full[slot_q];
        out_used  = hold_full[slot_q];
        out_data  = hold_full[slot_q] ? hold_word[slot_q] : '0;
        out_frame = hold_full[slot_q] & (slot_q <= prev_q);
        if (hold_full[slot_q]) begin
          // Slot stays put while stalled: only 'take' can empty it.
          if (out_ready) begin
            prev_d = slot_q;
            slot_d = next_full(full_nxt, slot_q + 1'b1);
            if (!en && (slot_q <= prev_q)) begin
              state_d = ST_IDLE;
              prev_d  = LAST_SLOT;
            end
          end
        end else begin
          slot_d = next_full(full_nxt, prev_q + 1'b1);
          if (!en && (hold_full == '0)) begin
            state_d = ST_IDLE;
            prev_d  = LAST_SLOT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= LAST_SLOT;
    else        prev_q <= prev_d;
  end
`else
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    out_sel   = slot_q;
    out_valid = 1'b0;
    out_used  = 1'b0;
    out_frame = 1'b0;
    out_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_SCAN;
          slot_d  = '0;
        end
      end
      ST_SCAN: begin
        out_valid = 1'b1;
        out_used  = hold_full[slot_q];
        out_data  = hold_full[slot_q] ? hold_word[slot_q] : '0;
        out_frame = (slot_q == '0);
        // out_valid is always 1 here, so out_ready alone means fire.
        if (out_ready) begin
          slot_d = slot_q + 1'b1;
          // en matters only at the frame boundary; a frame always completes.
          if (slot_q == LAST_SLOT && !en) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

endmodule
